eco32_alu: RTL and testbench
============================

Name: eco32_alu

Overview:
- 32-bit integer ALU for the ECO32 CPU execute stage.
- Computes one of seven arithmetic/logic results and, in parallel, a signed or unsigned six-way comparison flag for conditional branches.
- Inputs are sampled on the rising clock edge. Both results are registered, so latency is exactly one cycle.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is required to work.

Ports:
- clk  input  1  system clock, rising edge active.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and controls are valid this cycle.
- operation  input  3  arithmetic/logic operation select.
- left_operand  input  32  operand A.
- right_operand  input  32  operand B.
- signed_comparison  input  1  1 = two's-complement compare; 0 = unsigned compare.
- comparison_operation  input  3  comparison select.
- out_valid  output  1  registered copy of in_valid.
- result  output  32  registered operation result.
- comparison_result  output  1  registered comparison outcome.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while reset_n is 0, out_valid, result and comparison_result are 0, immediately and independent of clk.
- The first capture after reset release happens on the next rising edge.
- Each rising edge (reset_n = 1):
  - out_valid <= in_valid.
  - result and comparison_result load the values computed from the current inputs.
  - The result registers load every cycle regardless of in_valid. Consumers qualify them with out_valid.
- Operation encodings (shared constants):
  - ADD=0: A+B modulo 2^32.
  - SUB=1: A−B modulo 2^32.
  - AND=2: A&B.
  - OR=3: A|B.
  - XOR=4: A^B.
  - XNOR=5: ~(A^B).
  - HIGH=6: {B[15:0], 16'h0000}; A is ignored.
  - 7: reserved, result=0.
- No carry or overflow outputs exist. Wrap-around is silent.
- Comparison encodings (shared constants):
  - EQUAL=0: A==B.
  - NOT_EQUAL=1: A!=B.
  - LESS_THAN=2: A<B.
  - LESS_EQUAL=3: A<=B.
  - GREATER_THAN=4: A>B.
  - GREATER_EQUAL=5: A>=B.
  - 6 and 7: reserved, comparison_result=0.
- The comparison is evaluated every cycle, independent of operation.
- signed_comparison is ignored for EQUAL and NOT_EQUAL.
- Comparison datapath: one 33-bit subtractor computing A + ~B + 1.
  - carry-out = 1 means A >= B unsigned.
  - zero = (A==B).
  - signed less = N xor V, where N is difference bit 31 and V is the signed overflow of A−B.
  - less-equal = less | zero; greater = ~less-equal; greater-equal = ~less.
- Boundary values:
  - 0x80000000 vs 0x7FFFFFFF: signed less = 1, unsigned less = 0.
  - Equal operands: LESS_THAN and GREATER_THAN give 0; LESS_EQUAL and GREATER_EQUAL give 1, in both modes.
- No internal state beyond the output registers. Back-to-back inputs are accepted every cycle with no stall.

Decomposition:
- Package eco32_alu_pkg holds the operation and comparison encodings as 3-bit localparams/enums.
- One sub-module, eco32_alu_compare:
  - Combinational.
  - Inputs: A, B, signed_comparison, comparison_operation.
  - Output: the comparison flag.
  - Contains the 33-bit subtractor and flag logic.
- The top level holds the operation mux and the output registers.

Test Plan:
- Reset:
  - Assert reset_n=0 mid-operation → out_valid, result and comparison_result read 0 without a clock edge.
  - Release reset, then one edge later → out_valid follows in_valid.
- Arithmetic:
  - ADD 0x0472b8af+0x39a01111 → 0x3e12c9c0.
  - ADD 0xc0000000+0x50000000 → 0x10000000 (wrap).
  - SUB 0x39a01111−0x0472b8af → 0x352d5862.
  - SUB 0x10000000−0x20000000 → 0xf0000000.
  - Each result appears one cycle after input.
- Logic, with A=0x39a01111, B=0x0472b8af:
  - HIGH → 0xb8af0000.
  - XOR → 0x3dd2a9be.
  - XNOR → 0xc22d5641.
  - AND → 0x00201001.
  - OR → 0x3df2b9bf.
- Equality:
  - A=0x39a01111, B=0x0472b8af → EQUAL=0, NOT_EQUAL=1 in both modes.
  - B=A → EQUAL=1, NOT_EQUAL=0 in both modes.
- Ordering, A=0x0472b8af vs B=0xc9a01111:
  - unsigned: LT=1, LE=1, GT=0, GE=0.
  - signed: LT=0, LE=0, GT=1, GE=1.
- Ordering, other pairs:
  - A=0xb472b8af vs B=0xc9a01111 → LT=1 in both modes.
  - A=B=0xc0000000 → LT=0, LE=1, GT=0, GE=1 in both modes.
  - Reserved operation 7 and reserved comparison 6 → result=0 and comparison_result=0.

Source files
------------

// File: rtl/eco32_alu_pkg.sv
// ECO32 ALU shared encodings.
// Holds the 3-bit operation and comparison select encodings. The top level
// and the comparison unit both import these encodings.
package eco32_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_HIGH = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_EQUAL         = 3'd0,
    CMP_NOT_EQUAL     = 3'd1,
    CMP_LESS_THAN     = 3'd2,
    CMP_LESS_EQUAL    = 3'd3,
    CMP_GREATER_THAN  = 3'd4,
    CMP_GREATER_EQUAL = 3'd5
  } alu_cmp_e;

endpackage

// File: rtl/eco32_alu_compare.sv
// ECO32 ALU comparison unit (combinational).
// Ports:
//   left_operand, right_operand  operands A and B
//   signed_comparison            1 = two's-complement, 0 = unsigned ordering
//   comparison_operation         comparison select (alu_cmp_e); 6/7 give 0
//   flag                         comparison outcome
module eco32_alu_compare
  import eco32_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] left_operand,
  input  logic [WIDTH-1:0] right_operand,
  input  logic             signed_comparison,
  input  logic [2:0]       comparison_operation,
  output logic             flag
);

  logic [WIDTH:0] diff;
  logic           carry;
  logic           zero;
  logic           negative;
  logic           overflow;
  logic           less;
  logic           less_equal;

  // Single subtractor A + ~B + 1; carry-out set means A >= B unsigned.
  assign diff     = {1'b0, left_operand} + {1'b0, ~right_operand} + {{WIDTH{1'b0}}, 1'b1};
  assign carry    = diff[WIDTH];
  // A - B wraps to zero only when the operands are equal.
  assign zero     = (diff[WIDTH-1:0] == '0);
  assign negative = diff[WIDTH-1];
  // Overflow only possible when operand signs differ and the result sign
  // disagrees with A.
  assign overflow = (left_operand[WIDTH-1] != right_operand[WIDTH-1]) &&
                    (diff[WIDTH-1] != left_operand[WIDTH-1]);

  assign less       = signed_comparison ? (negative ^ overflow) : ~carry;
  assign less_equal = less | zero;

  always_comb begin
    flag = 1'b0;
    case (comparison_operation)
      CMP_EQUAL:         flag = zero;
      CMP_NOT_EQUAL:     flag = ~zero;
      CMP_LESS_THAN:     flag = less;
      CMP_LESS_EQUAL:    flag = less_equal;
      CMP_GREATER_THAN:  flag = ~less_equal;
      CMP_GREATER_EQUAL: flag = ~less;
      default:           flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/eco32_alu.sv
// ECO32 execute-stage ALU, one cycle latency.
// Ports:
//   clk, reset_n               clock (rising edge), async active-low reset
//   in_valid                   inputs valid this cycle
//   operation                  arithmetic/logic select (alu_op_e); 7 gives 0
//   left_operand/right_operand operands A and B
//   signed_comparison          signed (1) / unsigned (0) ordering
//   comparison_operation       comparison select (alu_cmp_e)
//   out_valid                  registered in_valid
//   result                     registered operation result
//   comparison_result          registered comparison flag
// Result registers load every cycle; consumers qualify them with out_valid.
module eco32_alu
  import eco32_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] left_operand,
  input  logic [WIDTH-1:0] right_operand,
  input  logic             signed_comparison,
  input  logic [2:0]       comparison_operation,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             comparison_result
);

  logic [WIDTH-1:0] op_result;
  logic             cmp_flag;

  always_comb begin
    op_result = '0;
    case (operation)
      OP_ADD:  op_result = left_operand + right_operand;
      OP_SUB:  op_result = left_operand - right_operand;
      OP_AND:  op_result = left_operand & right_operand;
      OP_OR:   op_result = left_operand | right_operand;
      OP_XOR:  op_result = left_operand ^ right_operand;
      OP_XNOR: op_result = ~(left_operand ^ right_operand);
      OP_HIGH: op_result = {right_operand[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: op_result = '0;
    endcase
  end

  eco32_alu_compare #(
    .WIDTH(WIDTH)
  ) u_compare (
    .left_operand        (left_operand),
    .right_operand       (right_operand),
    .signed_comparison   (signed_comparison),
    .comparison_operation(comparison_operation),
    .flag                (cmp_flag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      result            <= '0;
      comparison_result <= 1'b0;
    end else begin
      out_valid         <= in_valid;
      result            <= op_result;
      comparison_result <= cmp_flag;
    end
  end

endmodule

// File: tb/tb_eco32_alu.sv
// Self-checking bench for eco32_alu: directed vectors plus randomized
// stimulus against a behavioural model.
module tb_eco32_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [2:0]  operation;
  logic [31:0] left_operand;
  logic [31:0] right_operand;
  logic        signed_comparison;
  logic [2:0]  comparison_operation;
  logic        out_valid;
  logic [31:0] result;
  logic        comparison_result;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  eco32_alu #(
    .WIDTH(32)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_valid            (in_valid),
    .operation           (operation),
    .left_operand        (left_operand),
    .right_operand       (right_operand),
    .signed_comparison   (signed_comparison),
    .comparison_operation(comparison_operation),
    .out_valid           (out_valid),
    .result              (result),
    .comparison_result   (comparison_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a ^ b);
      6: return b * 32'h0001_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_cmp(input logic sgn, input int cmp, input logic [31:0] a, input logic [31:0] b);
    logic lt, eq;
    eq = (a == b);
    lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    case (cmp)
      0: return eq;
      1: return !eq;
      2: return lt;
      3: return lt || eq;
      4: return !(lt || eq);
      5: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // Present inputs just after an edge; outputs are examined 1 ns after the
  // following edge, which is the one that captures them.
  task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [2:0] cmp, input logic vld);
    operation            = op;
    left_operand         = a;
    right_operand        = b;
    signed_comparison    = sgn;
    comparison_operation = cmp;
    in_valid             = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    apply(op, a, b, 1'b0, 3'd0, 1'b1);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check(tag, result, exp);
  endtask

  task automatic run_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [2:0] cmp, input logic exp);
    apply(3'd0, a, b, sgn, cmp, 1'b1);
    check(tag, {31'b0, comparison_result}, {31'b0, exp});
  endtask

  // Expected flags per comparison code 0..5, LSB = EQUAL.
  task automatic run_all_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic sgn, input logic [5:0] exp_bits);
    for (int c = 0; c < 6; c++)
      run_cmp($sformatf("%s.c%0d.s%0d", tag, c, sgn), a, b, sgn, 3'(c), exp_bits[c]);
  endtask

  logic [31:0] corner [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'hC000_0000};

  initial begin
    reset_n = 1'b0;
    apply(3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.cmp", {31'b0, comparison_result}, 32'd0);

    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("release.valid", {31'b0, out_valid}, 32'd1);

    // Asynchronous reset mid-operation, checked before any clock edge.
    apply(3'd0, 32'h1234_5678, 32'h1234_5678, 1'b0, 3'd0, 1'b1);
    check("pre_async.result", result, 32'h2468_ACF0);
    #2 reset_n = 1'b0;
    #1;
    check("async.valid", {31'b0, out_valid}, 32'd0);
    check("async.result", result, 32'd0);
    check("async.cmp", {31'b0, comparison_result}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("add", 3'd0, 32'h0472b8af, 32'h39a01111, 32'h3e12c9c0);
    run_op("add.wrap", 3'd0, 32'hc0000000, 32'h50000000, 32'h10000000);
    run_op("sub", 3'd1, 32'h39a01111, 32'h0472b8af, 32'h352d5862);
    run_op("sub.wrap", 3'd1, 32'h10000000, 32'h20000000, 32'hf0000000);
    run_op("high", 3'd6, 32'h39a01111, 32'h0472b8af, 32'hb8af0000);
    run_op("xor", 3'd4, 32'h39a01111, 32'h0472b8af, 32'h3dd2a9be);
    run_op("xnor", 3'd5, 32'h39a01111, 32'h0472b8af, 32'hc22d5641);
    run_op("and", 3'd2, 32'h39a01111, 32'h0472b8af, 32'h00201001);
    run_op("or", 3'd3, 32'h39a01111, 32'h0472b8af, 32'h3df2b9bf);
    run_op("op7", 3'd7, 32'h39a01111, 32'h0472b8af, 32'h0);

    for (int s = 0; s < 2; s++) begin
      run_cmp($sformatf("eq.ne.s%0d", s), 32'h39a01111, 32'h0472b8af, 1'(s), 3'd0, 1'b0);
      run_cmp($sformatf("ne.ne.s%0d", s), 32'h39a01111, 32'h0472b8af, 1'(s), 3'd1, 1'b1);
      run_cmp($sformatf("eq.eq.s%0d", s), 32'h39a01111, 32'h39a01111, 1'(s), 3'd0, 1'b1);
      run_cmp($sformatf("ne.eq.s%0d", s), 32'h39a01111, 32'h39a01111, 1'(s), 3'd1, 1'b0);
      run_cmp($sformatf("lt.b472.s%0d", s), 32'hb472b8af, 32'hc9a01111, 1'(s), 3'd2, 1'b1);
      // GE, GT, LE, LT, NE, EQ (MSB first)
      run_all_cmp("same.c0", 32'hc0000000, 32'hc0000000, 1'(s), 6'b101001);
      run_cmp($sformatf("cmp6.s%0d", s), 32'h1, 32'h1, 1'(s), 3'd6, 1'b0);
      run_cmp($sformatf("cmp7.s%0d", s), 32'h1, 32'h2, 1'(s), 3'd7, 1'b0);
    end
    run_all_cmp("ord.u", 32'h0472b8af, 32'hc9a01111, 1'b0, 6'b001110);
    run_all_cmp("ord.s", 32'h0472b8af, 32'hc9a01111, 1'b1, 6'b110010);
    run_cmp("minmax.s.lt", 32'h80000000, 32'h7FFFFFFF, 1'b1, 3'd2, 1'b1);
    run_cmp("minmax.u.lt", 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'd2, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      logic [2:0]  op, cmp;
      logic        sgn, vld;
      a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      op  = 3'($urandom_range(0, 7));
      cmp = 3'($urandom_range(0, 7));
      sgn = 1'($urandom_range(0, 1));
      vld = 1'($urandom_range(0, 1));
      apply(op, a, b, sgn, cmp, vld);
      check($sformatf("rnd%0d.valid", i), {31'b0, out_valid}, {31'b0, vld});
      check($sformatf("rnd%0d.op%0d", i, op), result, model_result(int'(op), a, b));
      check($sformatf("rnd%0d.cmp%0d.s%0d", i, cmp, sgn), {31'b0, comparison_result},
            {31'b0, model_cmp(sgn, int'(cmp), a, b)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
